// File: rtl/inst_decode_buf.sv
// ---------------------------------------------------------------------------
// inst_decode_buf
//   Instruction buffer between fetch and the immediate generator / control
//   decode. Instructions are accepted over a valid/ready handshake and held
//   in a small FIFO. Each one is pre-decoded into an immediate-format select
//   and an illegal-opcode flag on the way in. The head entry is presented
//   downstream. A flush (branch/jump redirect) empties the buffer.
//
// Ports
//   clk, rst_n      core clock, synchronous active-low reset
//   flush           drop every buffered entry and any handshake this cycle
//   in_valid/ready  fetch-side handshake; in_ready is registered (count != DEPTH)
//   in_inst, in_pc  fetched instruction word and its PC
//   out_valid/ready decode-side handshake; out_valid = (count != 0)
//   out_inst        head instruction, NOP_INST when empty
//   out_pc          head PC, 0 when empty
//   out_imm_sel     head immediate format (0 I/R, 1 S, 2 B, 3 U, 4 J), 0 when empty
//   out_illegal     head opcode unrecognised, 0 when empty
// ---------------------------------------------------------------------------

// Opcode pre-decode. This is pure combinational logic, so the result can be
// stored next to the instruction when it is enqueued.
module inst_decode_buf_predec (
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       illegal
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] SEL_I = 3'd0;
    localparam logic [2:0] SEL_S = 3'd1;
    localparam logic [2:0] SEL_B = 3'd2;
    localparam logic [2:0] SEL_U = 3'd3;
    localparam logic [2:0] SEL_J = 3'd4;

    always_comb begin
        imm_sel = SEL_I;
        illegal = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_sel = SEL_I;
            OP_STORE:                            imm_sel = SEL_S;
            OP_BRANCH:                           imm_sel = SEL_B;
            OP_LUI, OP_AUIPC:                    imm_sel = SEL_U;
            OP_JAL:                              imm_sel = SEL_J;
            // R-type carries no immediate. The select value is unused downstream.
            OP_REG:                              imm_sel = SEL_I;
            default:                             illegal = 1'b1;
        endcase
    end
endmodule

module inst_decode_buf #(
    parameter int          DEPTH    = 2,
    parameter int          PC_WIDTH = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [2:0]          out_imm_sel,
    output logic                out_illegal
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that full (count == DEPTH) and empty (count == 0)
    // can be told apart while the pointers wrap freely.
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]         inst;
        logic [PC_WIDTH-1:0] pc;
        logic [2:0]          imm_sel;
        logic                illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             enq;
    logic             deq;
    logic [2:0]       in_imm_sel;
    logic             in_illegal;
    entry_t           in_entry;
    entry_t           head;

    inst_decode_buf_predec u_predec (
        .opcode  (in_inst[6:0]),
        .imm_sel (in_imm_sel),
        .illegal (in_illegal)
    );

    // Both handshake qualifiers come from registered count only. A dequeue in
    // the same cycle therefore never opens in_ready combinationally.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);

    // Flush drops any handshake in the same cycle. Fetch must re-present
    // the instruction it offered in that cycle.
    assign enq = in_valid  && in_ready  && !flush;
    assign deq = out_valid && out_ready && !flush;

    always_comb begin
        in_entry         = '0;
        in_entry.inst    = in_inst;
        in_entry.pc      = in_pc;
        in_entry.imm_sel = in_imm_sel;
        in_entry.illegal = in_illegal;
    end

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset. Its contents are never observed while count is 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head        = mem_q[rd_ptr_q];
    assign out_inst    = out_valid ? head.inst    : NOP_INST;
    assign out_pc      = out_valid ? head.pc      : '0;
    assign out_imm_sel = out_valid ? head.imm_sel : 3'd0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
endmodule

// File: tb/tb_inst_decode_buf.sv
module tb_inst_decode_buf;
  localparam int DEPTH    = 2;
  localparam int PC_WIDTH = 32;

  logic                clk = 1'b0;
  logic                rst_n, flush, in_valid, out_ready;
  logic                in_ready, out_valid, out_illegal;
  logic [31:0]         in_inst, out_inst;
  logic [PC_WIDTH-1:0] in_pc, out_pc;
  logic [2:0]          out_imm_sel;

  inst_decode_buf #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted {inst, pc} entries in FIFO order.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];
  bit   model_ok = 0;

  // Immediate format and illegal flag taken directly from the opcode table.
  function automatic logic [3:0] ref_dec(input logic [31:0] inst);
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: return {3'd0, 1'b0};
      7'b0100011:                                     return {3'd1, 1'b0};
      7'b1100011:                                     return {3'd2, 1'b0};
      7'b0110111, 7'b0010111:                         return {3'd3, 1'b0};
      7'b1101111:                                     return {3'd4, 1'b0};
      7'b0110011:                                     return {3'd0, 1'b0};
      default:                                        return {3'd0, 1'b1};
    endcase
  endfunction

  task automatic check_outputs();
    logic        ev;
    logic [3:0]  d;
    ev = (q.size() != 0);
    chk("in_ready",  in_ready,  q.size() != DEPTH);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      d = ref_dec(q[0].inst);
      chk("out_inst",    out_inst,    q[0].inst);
      chk("out_pc",      out_pc,      q[0].pc);
      chk("out_imm_sel", out_imm_sel, d[3:1]);
      chk("out_illegal", out_illegal, d[0]);
    end else begin
      chk("out_inst_empty",    out_inst,    32'h0000_0013);
      chk("out_pc_empty",      out_pc,      0);
      chk("out_imm_sel_empty", out_imm_sel, 0);
      chk("out_illegal_empty", out_illegal, 0);
    end
  endtask

  // One clock: drive on the falling edge, check just after, advance the model
  // at the rising edge using the pre-edge occupancy.
  task automatic step(input logic rs, input logic fl, input logic iv,
                      input logic [31:0] inst, input logic [31:0] pc, input logic ordy);
    bit can_in, can_out;
    @(negedge clk);
    rst_n = rs; flush = fl; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
    #1;
    if (model_ok) check_outputs();
    can_in  = (q.size() != DEPTH);
    can_out = (q.size() != 0);
    @(posedge clk);
    if (!rs) begin
      q.delete();
      model_ok = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      ent_t e;
      if (can_out && ordy) void'(q.pop_front());
      if (can_in && iv) begin
        e.inst = inst; e.pc = pc;
        q.push_back(e);
      end
    end
  endtask

  localparam logic [6:0] OPS [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                                      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                                      7'b1101111, 7'b0110011, 7'b0000000, 7'b1111111};

  initial begin
    rst_n = 0; flush = 0; in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h40; out_ready = 0;

    // Reset for two cycles with fetch already presenting an instruction.
    step(0, 0, 1, 32'h00500093, 32'h40, 0);
    step(0, 0, 1, 32'h00500093, 32'h40, 0);
    step(1, 0, 0, 0, 0, 0);                         // checks post-reset idle state

    // Single pass and latency.
    step(1, 0, 1, 32'h00500093, 32'h1000, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("single_inst", out_inst, 32'h00500093);
    chk("single_sel",  out_imm_sel, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("single_drained", out_valid, 0);

    // Fill to full with backpressure, hold a third push, then drain.
    step(1, 0, 1, 32'h00112223, 32'h2000, 0);
    step(1, 0, 1, 32'h00208463, 32'h2004, 0);
    step(1, 0, 1, 32'h008000ef, 32'h2008, 0);       // held: buffer is full
    chk("full_ready", in_ready, 0);
    chk("full_head_sel", out_imm_sel, 1);
    // Full + simultaneous dequeue: only the dequeue happens.
    step(1, 0, 1, 32'h008000ef, 32'h2008, 1);
    step(1, 0, 1, 32'h008000ef, 32'h2008, 0);       // accepted here
    chk("after_deq_sel", out_imm_sel, 2);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("held_sel", out_imm_sel, 4);
    step(1, 0, 0, 0, 0, 1);

    // Flush with concurrent enqueue and dequeue handshakes.
    step(1, 0, 1, 32'h00500093, 32'h3000, 0);
    step(1, 1, 1, 32'h008000ef, 32'h3004, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    step(1, 0, 1, 32'h008000ef, 32'h3100, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("post_flush_sel", out_imm_sel, 4);

    // Decode sweep: lui, auipc, all-zero word.
    step(1, 0, 1, 32'h123450b7, 32'h4000, 1);
    step(1, 0, 1, 32'h00001097, 32'h4004, 1);
    chk("lui_sel", out_imm_sel, 3);
    step(1, 0, 1, 32'h00000000, 32'h4008, 1);
    chk("auipc_sel", out_imm_sel, 3);
    step(1, 0, 0, 0, 0, 1);
    chk("zero_illegal", out_illegal, 1);
    step(1, 0, 0, 0, 0, 1);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = OPS[$urandom_range(0, 11)];
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1, w, $urandom, $urandom_range(0, 2) != 0);
    end
    step(1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
